// File: rtl/adder_seq_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// adder_seq_ctrl_pkg : FSM state type and slice width shared by the
// sequential nibble adder.                                   rev 1.0
// ----------------------------------------------------------------------
package adder_seq_ctrl_pkg;

  localparam int unsigned c_nibble_w = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/adder_seq_ctrl_adder.sv
`default_nettype none
// ----------------------------------------------------------------------
// Adder_4bit : combinational 4-bit ripple slice with carry in/out.
//                                                            rev 1.0
// ----------------------------------------------------------------------
module Adder_4bit
  import adder_seq_ctrl_pkg::*;
(
  input  logic [c_nibble_w-1:0] A,
  input  logic [c_nibble_w-1:0] B,
  input  logic                  C_in,
  output logic [c_nibble_w-1:0] S,
  output logic                  C_out
);

  assign {C_out, S} = (c_nibble_w+1)'(A) + (c_nibble_w+1)'(B) + (c_nibble_w+1)'(C_in);

endmodule
`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// adder_seq_ctrl : W-bit add (optional subtract with ADDER_SEQ_SUB_EN)
// through one shared 4-bit slice, one nibble per clock, LSB first. rev 1.0
// ----------------------------------------------------------------------
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [c_nibble_w*NIBBLES-1:0]  A,
  input  logic [c_nibble_w*NIBBLES-1:0]  B,
  input  logic                           C_in,
`ifdef ADDER_SEQ_SUB_EN
  input  logic                           sub,
`endif
  output logic [c_nibble_w*NIBBLES-1:0]  S,
  output logic                           C_out,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned W     = c_nibble_w * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t                  r_state;
  state_t                  w_next;
  logic [W-1:0]            r_a;
  logic [W-1:0]            r_b;
  logic                    r_carry;
  logic [IDX_W-1:0]        r_idx;
  logic [c_nibble_w-1:0]   w_a_nib;
  logic [c_nibble_w-1:0]   w_b_nib;
  logic [c_nibble_w-1:0]   w_sum;
  logic                    w_cout;
  logic                    w_last;
  logic                    w_accept;
  logic [W-1:0]            w_b_lat;
  logic                    w_cin_lat;

  // Subtraction is A + ~B + 1; the adder itself never changes.
`ifdef ADDER_SEQ_SUB_EN
  assign w_b_lat   = sub ? ~B : B;
  assign w_cin_lat = sub ? 1'b1 : C_in;
`else
  assign w_b_lat   = B;
  assign w_cin_lat = C_in;
`endif

  assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_accept = start && (r_state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_nib = r_a[k*c_nibble_w +: c_nibble_w];
        w_b_nib = r_b[k*c_nibble_w +: c_nibble_w];
      end
    end
  end

  Adder_4bit u_adder (
    .A     (w_a_nib),
    .B     (w_b_nib),
    .C_in  (r_carry),
    .S     (w_sum),
    .C_out (w_cout)
  );

  // Index holds on the last nibble; the next accepted start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      S       <= '0;
      C_out   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= w_b_lat;
      r_carry <= w_cin_lat;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (r_idx == IDX_W'(k)) S[k*c_nibble_w +: c_nibble_w] <= w_sum;
      end
      r_carry <= w_cout;
      if (w_last) C_out <= w_cout;
      else        r_idx <= r_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// Self-checking bench for adder_seq_ctrl: directed cases plus randomized
// operands against an arithmetic reference model.
module tb_adder_seq_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         sub_in;
  logic [W-1:0] s;
  logic         c_out;
  logic         busy;
  logic         done;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .C_in  (cin_in),
`ifdef ADDER_SEQ_SUB_EN
    .sub   (sub_in),
`endif
    .S     (s),
    .C_out (c_out),
    .busy  (busy),
    .done  (done)
  );

  // {C_out,S}: plain sum, or difference with "no borrow" as carry.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sb);
    logic [W-1:0] d;
    if (sb) begin
      d = a - b;
      ref_sum = {(a >= b), d};
    end else begin
      ref_sum = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    end
  endfunction

  // Launch one operation and wait (bounded) for done; inputs are scrambled during RUN.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sb, output logic [W:0] res, output int edges,
                       output int busy_cnt);
    @(negedge clk);
    a_in = a; b_in = b; cin_in = cin; sub_in = sb; start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    edges    = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < 40) begin
      a_in   = W'($urandom);
      b_in   = W'($urandom);
      cin_in = 1'($urandom);
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
    end
    res = {c_out, s};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ncmp++; if (s !== '0)     begin nfail++; $display("FAIL reset_S: got %h want 0", s); end
    ncmp++; if (c_out !== 0)  begin nfail++; $display("FAIL reset_Cout: got %b want 0", c_out); end
    ncmp++; if (busy !== 0)   begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
    ncmp++; if (done !== 0)   begin nfail++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_latency();
    logic [W:0] res; int edges, bc;
    do_op('0, '0, 1'b0, 1'b0, res, edges, bc);
    ncmp++; if (res !== '0)  begin nfail++; $display("FAIL zero_sum: got %h want 0", res); end
    ncmp++; if (edges !== NIBBLES+1) begin nfail++; $display("FAIL zero_latency: got %0d want %0d", edges, NIBBLES+1); end
    ncmp++; if (bc !== NIBBLES) begin nfail++; $display("FAIL zero_busy_cycles: got %0d want %0d", bc, NIBBLES); end
    @(posedge clk); #1;
    ncmp++; if (done !== 0) begin nfail++; $display("FAIL done_pulse_width: got %b want 0", done); end
    ncmp++; if ({c_out, s} !== res || busy !== 0) begin
      nfail++; $display("FAIL idle_hold: got %h busy %b want %h busy 0", {c_out, s}, busy, res);
    end
  endtask

  task automatic test_directed_back_to_back();
    logic [W:0] res; int edges, bc;
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, res, edges, bc);
    ncmp++; if (res !== 17'h05556) begin nfail++; $display("FAIL sum_1234_4321: got %h want 05556", res); end
    // Second start issued while the first sits in DONE.
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, res, edges, bc);
    ncmp++; if (res !== 17'h10000) begin nfail++; $display("FAIL ripple_ffff_0001: got %h want 10000", res); end
    ncmp++; if (edges !== NIBBLES+1) begin nfail++; $display("FAIL b2b_latency: got %0d want %0d", edges, NIBBLES+1); end
  endtask

  task automatic test_start_while_busy();
    logic [W:0] exp, first; int ndone;
    exp = ref_sum(16'h1234, 16'h0F0F, 1'b0, 1'b0);
    first = '0; ndone = 0;
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h0F0F; cin_in = 1'b0; sub_in = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_in = 16'hFFFF; b_in = 16'hFFFF; cin_in = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (ndone == 0) first = {c_out, s};
        ndone++;
      end
    end
    ncmp++; if (ndone !== 1) begin nfail++; $display("FAIL busy_start_done_count: got %0d want 1", ndone); end
    ncmp++; if (first !== exp) begin nfail++; $display("FAIL busy_start_result: got %h want %h", first, exp); end
  endtask

  task automatic test_reset_mid_run();
    logic [W:0] res; int edges, bc, ndone;
    @(negedge clk);
    a_in = 16'hFFFF; b_in = 16'hFFFF; cin_in = 1'b0; sub_in = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    ncmp++; if ({c_out, s} !== '0) begin nfail++; $display("FAIL abort_result: got %h want 0", {c_out, s}); end
    ncmp++; if (busy !== 0 || done !== 0) begin nfail++; $display("FAIL abort_flags: got busy %b done %b want 0 0", busy, done); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    ncmp++; if (ndone !== 0) begin nfail++; $display("FAIL abort_no_done: got %0d want 0", ndone); end
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, res, edges, bc);
    ncmp++; if (res !== 17'h05556 || edges !== NIBBLES+1) begin
      nfail++; $display("FAIL after_abort: got %h in %0d edges want 05556 in %0d", res, edges, NIBBLES+1);
    end
  endtask

  task automatic test_random();
    logic [W:0] res, exp; logic [W-1:0] a, b; logic cin, sb; int edges, bc;
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sb = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
      sb = 1'($urandom);
`endif
      if (i == 0) begin a = '1; b = '1; cin = 1'b1; sb = 1'b0; end
      exp = ref_sum(a, b, cin, sb);
      do_op(a, b, cin, sb, res, edges, bc);
      ncmp++; if (res !== exp) begin
        nfail++; $display("FAIL random_%0d: A=%h B=%h cin=%b sub=%b got %h want %h", i, a, b, cin, sb, res, exp);
      end
      ncmp++; if (edges !== NIBBLES+1) begin nfail++; $display("FAIL random_latency_%0d: got %0d want %0d", i, edges, NIBBLES+1); end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
  endtask

`ifdef ADDER_SEQ_SUB_EN
  task automatic test_sub();
    logic [W:0] res; int edges, bc;
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, res, edges, bc);
    ncmp++; if (res !== 17'h0FFFE) begin nfail++; $display("FAIL sub_5_7: got %h want 0FFFE", res); end
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, res, edges, bc);
    ncmp++; if (res !== 17'h10002) begin nfail++; $display("FAIL sub_7_5: got %h want 10002", res); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_latency();
    test_directed_back_to_back();
    test_start_while_busy();
    test_reset_mid_run();
`ifdef ADDER_SEQ_SUB_EN
    test_sub();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", ncmp);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk, input, 1, rising-edge clock.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: start, input, 1, request to begin an addition.
REQ-006 Port: A, input, W, operand A, sampled with start.
REQ-007 Port: B, input, W, operand B, sampled with start.
REQ-008 Port: C_in, input, 1, carry-in, sampled with start.
REQ-009 Port: S, output, W, registered sum.
REQ-010 Port: C_out, output, 1, registered final carry.
REQ-011 Port: busy, output, 1, high while a computation is in progress.
REQ-012 Port: done, output, 1, one-cycle pulse when S/C_out are valid.

Function
REQ-013 The block SHALL compute {C_out,S} = A + B + C_in through a single shared 4-bit adder, one nibble per clock, LSB nibble first.
REQ-014 FSM SHALL have states IDLE, RUN and DONE; reset state is IDLE.
REQ-015 IDLE/DONE with start=1: latch A, B and C_in, clear the nibble index, go to RUN.
REQ-016 RUN: each edge writes adder sum into S[4i+3:4i], registers adder carry as the next carry-in, and increments i.
REQ-017 After the edge writing nibble NIBBLES-1: go to DONE and set C_out to the final carry.
REQ-018 done SHALL be high for exactly the one cycle in DONE; DONE returns to IDLE next edge unless start=1 (back-to-back accepted).
REQ-019 Latency: done asserts after exactly NIBBLES+1 rising edges, counting from the edge that sampled start.
REQ-020 busy SHALL equal (state==RUN); start while busy SHALL be ignored and SHALL NOT disturb latched operands.
REQ-021 S and C_out SHALL hold their last result in IDLE until the next accepted start; input changes during RUN SHALL have no effect.
REQ-022 Carry SHALL wrap without saturation: overflow beyond W bits appears only on C_out.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, S=0, C_out=0, busy=0, done=0, index=0, and clear latched operands and carry, including mid-RUN; no done follows an aborted operation.

Configuration
REQ-024 Macro ADDER_SEQ_SUB_EN SHALL add input port sub (1 bit, sampled with start).
REQ-025 With ADDER_SEQ_SUB_EN and sub=1: latch ~B and force initial carry to 1, giving S = A - B mod 2^W; C_out=1 means no borrow.
REQ-026 Without ADDER_SEQ_SUB_EN: no sub port; behaviour is addition only.

Structure
REQ-027 The shared package SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the nibble-width constant 4.
REQ-028 The design SHALL instantiate exactly one existing Adder_4bit (ports A, B, C_in, S, C_out) as its only sub-module; no other arithmetic is permitted.

Verification
REQ-029 Reset, start with A=0x0000, B=0x0000, C_in=0 -> S=0x0000, C_out=0; done after 5 edges, busy high for 4 cycles.
REQ-030 A=0x1234, B=0x4321, C_in=1 -> S=0x5556, C_out=0.
REQ-031 A=0xFFFF, B=0x0001, C_in=0 -> S=0x0000, C_out=1, confirming the carry ripples across all nibbles.
REQ-032 Second start pulsed mid-RUN with different operands -> ignored; the first result completes unchanged and only one done is produced.
REQ-033 rst_n low during nibble 2 of A=0xFFFF, B=0xFFFF -> S=0, C_out=0, busy=0 immediately; no done; next start then completes normally.
REQ-034 ADDER_SEQ_SUB_EN defined, sub=1, A=0x0005, B=0x0007 -> S=0xFFFE, C_out=0; A=0x0007, B=0x0005 -> S=0x0002, C_out=1.
